int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: NUM_IRQ, default 4, number of interrupt sources (2..8).
REQ-002 Parameter: PMA_SIZE, default 16, program-memory address width.
REQ-003 Parameter: VEC_BASE, default 16'h0010, vector address of source 0.
REQ-004 Parameter: VEC_STRIDE, default 4, vector address spacing between sources.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 irq_in  input  NUM_IRQ  raw interrupt lines, level inputs, rising-edge detected.
REQ-008 mask_wen  input  1  write strobe for mask register.
REQ-009 mask_wdata  input  NUM_IRQ  new mask value, 1 = source enabled.
REQ-010 ps_idle  input  1  sequencer is halted in IDLE.
REQ-011 ps_int_ack  input  1  sequencer accepts the offered vector this cycle.
REQ-012 ps_rti  input  1  sequencer executed return-from-interrupt.
REQ-013 int_req  output  1  vector offer valid to sequencer.
REQ-014 int_vec  output  PMA_SIZE  vector address, valid while int_req = 1.
REQ-015 int_id  output  3  index of offered / in-service source.
REQ-016 ps_wake  output  1  one-cycle pulse releasing sequencer from IDLE.
REQ-017 pending  output  NUM_IRQ  latched pending bits (unmasked and masked).
REQ-018 in_service  output  1  an interrupt handler is executing.

Function
REQ-019 Edge detect SHALL register irq_in each cycle; pending[i] sets one cycle after a 0->1 transition on irq_in[i]; held-high levels do not re-trigger.
REQ-020 Pending bits SHALL be set regardless of mask; mask only gates arbitration.
REQ-021 Eligible set = pending & mask; lowest index wins (fixed priority, source 0 highest).
REQ-022 FSM states: IDLE, OFFER, SERVICE.
REQ-023 IDLE -> OFFER when eligible set nonzero; winner index latched into int_id on the transition; int_req = 1 from next cycle.
REQ-024 int_vec SHALL equal VEC_BASE + int_id * VEC_STRIDE, truncated to PMA_SIZE bits, registered.
REQ-025 OFFER: int_req, int_vec, int_id SHALL hold stable until ps_int_ack; a higher-priority arrival does not change the offer.
REQ-026 OFFER + ps_int_ack -> SERVICE next cycle; pending[int_id] clears same edge; int_req drops to 0.
REQ-027 OFFER: if mask[int_id] is cleared via mask_wen before ack, offer is withdrawn (int_req = 0) and FSM returns to IDLE; pending bit retained.
REQ-028 SERVICE: in_service = 1; no new offer (no nesting); pending bits continue to accumulate.
REQ-029 SERVICE + ps_rti -> IDLE; next arbitration earliest the following cycle.
REQ-030 ps_rti outside SERVICE and ps_int_ack outside OFFER SHALL be ignored.
REQ-031 New edge on irq_in[i] in the same cycle pending[i] is cleared by ack: set wins; pending[i] = 1 afterward.
REQ-032 Repeated edges while pending[i] = 1 SHALL collapse into one pending event.
REQ-033 ps_wake SHALL pulse exactly one cycle when FSM enters OFFER while ps_idle = 1; no pulse if ps_idle = 0.
REQ-034 mask_wen takes effect on the next edge; mask write and arbitration in same cycle use old mask.
REQ-035 Latency: irq_in rise at edge N -> pending at N+1 -> OFFER entered at N+2 -> int_req visible after N+2.

Reset
REQ-036 reset = 1 at a rising edge SHALL force: FSM IDLE, pending = 0, mask = 0 (all disabled), int_req = 0, int_vec = 0, int_id = 0, ps_wake = 0, in_service = 0, edge-detect register = 0.
REQ-037 Reset mid-OFFER or mid-SERVICE SHALL abandon the interrupt with no ack/rti required.
REQ-038 irq_in already high when reset deasserts SHALL register as an edge on the first cycle after reset (edge register cleared to 0).

Verification
REQ-039 Mask = 4'b1111, pulse irq_in[2] -> pending = 4'b0100, int_req = 1, int_id = 2, int_vec = 16'h0018 two cycles later; ack -> pending = 0, in_service = 1.
REQ-040 irq_in[3] and irq_in[1] rise same cycle -> int_id = 1 offered; after ack + rti, int_id = 3 offered, int_vec = 16'h001C.
REQ-041 Mask = 4'b0000, pulse irq_in[0] -> pending[0] = 1, int_req stays 0; write mask = 4'b0001 -> offer int_id = 0 one cycle after mask takes effect.
REQ-042 ps_idle = 1, pulse irq_in[1] -> ps_wake high exactly one cycle coincident with OFFER entry; with ps_idle = 0 repeat -> ps_wake never asserts.
REQ-043 In SERVICE, pulse irq_in[0] three times -> pending[0] = 1 once, no offer until ps_rti, then one offer of int_id = 0.
REQ-044 Assert reset during OFFER -> all outputs at REQ-036 values next edge; no offer resumes with mask = 0.

Source files
------------

// File: rtl/int_ctrl_if.sv
// Handshake bundle between the interrupt controller and the program sequencer.
// The master modport is the sequencer/environment side; the slave modport is int_ctrl.
interface int_ctrl_if #(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned PMA_SIZE = 16
);
  logic [NUM_IRQ-1:0]  irq_in;
  logic                mask_wen;
  logic [NUM_IRQ-1:0]  mask_wdata;
  logic                ps_idle;
  logic                ps_int_ack;
  logic                ps_rti;
  logic                int_req;
  logic [PMA_SIZE-1:0] int_vec;
  logic [2:0]          int_id;
  logic                ps_wake;
  logic [NUM_IRQ-1:0]  pending;
  logic                in_service;

  modport master (
    output irq_in, mask_wen, mask_wdata, ps_idle, ps_int_ack, ps_rti,
    input  int_req, int_vec, int_id, ps_wake, pending, in_service
  );

  modport slave (
    input  irq_in, mask_wen, mask_wdata, ps_idle, ps_int_ack, ps_rti,
    output int_req, int_vec, int_id, ps_wake, pending, in_service
  );
endinterface

// File: rtl/int_ctrl.sv
// Fixed-priority, non-nesting interrupt controller: edge-detected sources, maskable
// arbitration, vector offer/ack handshake and return-from-interrupt to the sequencer.
module int_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned PMA_SIZE   = 16,
  parameter int unsigned VEC_BASE   = 32'h0000_0010,
  parameter int unsigned VEC_STRIDE = 4
) (
  input logic       clk,
  input logic       reset,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StOffer, StService} state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  irq_q, irq_prev_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [2:0]          int_id_q, int_id_d;
  logic [PMA_SIZE-1:0] int_vec_q, int_vec_d;
  logic                wake_q, wake_d;

  logic [NUM_IRQ-1:0]  irq_edge;
  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  id_onehot;
  logic [NUM_IRQ-1:0]  pend_clr;
  logic [2:0]          winner;
  logic                found;
  logic [PMA_SIZE-1:0] vec_calc;
  logic                withdraw;

  assign irq_edge  = irq_q & ~irq_prev_q;
  assign eligible  = pending_q & mask_q;
  assign id_onehot = NUM_IRQ'(1) << int_id_q;
  assign mask_d    = bus.mask_wen ? bus.mask_wdata : mask_q;
  assign vec_calc  = PMA_SIZE'(VEC_BASE + 32'(winner) * VEC_STRIDE);

  // Offered source disabled either already (mask written during arbitration) or right now.
  assign withdraw = ~|(mask_q & id_onehot) |
                    (bus.mask_wen & ~|(bus.mask_wdata & id_onehot));

  // Lowest eligible index wins.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (eligible[i] && !found) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    int_id_d  = int_id_q;
    int_vec_d = int_vec_q;
    wake_d    = 1'b0;
    pend_clr  = '0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          state_d   = StOffer;
          int_id_d  = winner;
          int_vec_d = vec_calc;
          wake_d    = bus.ps_idle;
        end
      end
      StOffer: begin
        if (bus.ps_int_ack) begin
          state_d  = StService;
          pend_clr = id_onehot;
        end else if (withdraw) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (bus.ps_rti) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A fresh edge on the source being acknowledged must survive the clear.
    pending_d = (pending_q & ~pend_clr) | irq_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      irq_q      <= '0;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      int_id_q   <= 3'd0;
      int_vec_q  <= '0;
      wake_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_q      <= bus.irq_in;
      irq_prev_q <= irq_q;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      int_id_q   <= int_id_d;
      int_vec_q  <= int_vec_d;
      wake_q     <= wake_d;
    end
  end

  assign bus.int_req    = (state_q == StOffer);
  assign bus.in_service = (state_q == StService);
  assign bus.int_id     = int_id_q;
  assign bus.int_vec    = int_vec_q;
  assign bus.ps_wake    = wake_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: latency, priority, masking, wake, collapse, set-wins and reset.
module tb_int_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  int_ctrl_if #(.NUM_IRQ(4), .PMA_SIZE(16)) bus ();

  int_ctrl #(
    .NUM_IRQ   (4),
    .PMA_SIZE  (16),
    .VEC_BASE  (32'h0000_0010),
    .VEC_STRIDE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_wen   = 1'b1;
    bus.mask_wdata = m;
    step(1);
    bus.mask_wen   = 1'b0;
  endtask

  task automatic ack();
    bus.ps_int_ack = 1'b1;
    step(1);
    bus.ps_int_ack = 1'b0;
  endtask

  task automatic rti();
    bus.ps_rti = 1'b1;
    step(1);
    bus.ps_rti = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.irq_in     = 4'b0000;
    bus.mask_wen   = 1'b0;
    bus.mask_wdata = 4'b0000;
    bus.ps_idle    = 1'b0;
    bus.ps_int_ack = 1'b0;
    bus.ps_rti     = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_int_req", 32'(bus.int_req), 32'd0);
    chk("rst_int_vec", 32'(bus.int_vec), 32'd0);
    chk("rst_int_id", 32'(bus.int_id), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_in_service", 32'(bus.in_service), 32'd0);
    chk("rst_ps_wake", 32'(bus.ps_wake), 32'd0);

    // Single source, full mask, sequencer idle: latency, vector, wake pulse.
    write_mask(4'b1111);
    bus.ps_idle = 1'b1;
    bus.irq_in  = 4'b0100;
    step(1);
    bus.irq_in  = 4'b0000;
    chk("t1_pending_n", 32'(bus.pending), 32'h0);
    step(1);
    chk("t1_pending_n1", 32'(bus.pending), 32'h4);
    chk("t1_req_n1", 32'(bus.int_req), 32'd0);
    step(1);
    chk("t1_req_n2", 32'(bus.int_req), 32'd1);
    chk("t1_id", 32'(bus.int_id), 32'd2);
    chk("t1_vec", 32'(bus.int_vec), 32'h18);
    chk("t1_wake", 32'(bus.ps_wake), 32'd1);
    step(1);
    chk("t1_req_hold", 32'(bus.int_req), 32'd1);
    chk("t1_wake_drop", 32'(bus.ps_wake), 32'd0);
    ack();
    chk("t1_req_ack", 32'(bus.int_req), 32'd0);
    chk("t1_pending_ack", 32'(bus.pending), 32'h0);
    chk("t1_insvc", 32'(bus.in_service), 32'd1);
    rti();
    chk("t1_insvc_rti", 32'(bus.in_service), 32'd0);
    bus.ps_idle = 1'b0;

    // Simultaneous sources 3 and 1: priority, then the lower-priority one after rti.
    bus.irq_in = 4'b1010;
    step(2);
    chk("t2_pending", 32'(bus.pending), 32'hA);
    step(1);
    bus.irq_in = 4'b0000;
    chk("t2_req", 32'(bus.int_req), 32'd1);
    chk("t2_id", 32'(bus.int_id), 32'd1);
    chk("t2_vec", 32'(bus.int_vec), 32'h14);
    chk("t2_no_wake", 32'(bus.ps_wake), 32'd0);
    ack();
    chk("t2_pending_ack", 32'(bus.pending), 32'h8);
    rti();
    chk("t2_req_rti", 32'(bus.int_req), 32'd0);
    step(1);
    chk("t2_req2", 32'(bus.int_req), 32'd1);
    chk("t2_id2", 32'(bus.int_id), 32'd3);
    chk("t2_vec2", 32'(bus.int_vec), 32'h1C);
    chk("t2_no_wake2", 32'(bus.ps_wake), 32'd0);
    ack();
    rti();
    chk("t2_pending_end", 32'(bus.pending), 32'h0);

    // Masked source latches pending but is not offered; stray ack is ignored.
    write_mask(4'b0000);
    bus.irq_in = 4'b0001;
    step(1);
    bus.irq_in = 4'b0000;
    step(1);
    chk("t3_pending", 32'(bus.pending), 32'h1);
    step(2);
    chk("t3_req_masked", 32'(bus.int_req), 32'd0);
    ack();
    chk("t3_stray_ack", 32'(bus.pending), 32'h1);
    write_mask(4'b0001);
    chk("t3_req_old_mask", 32'(bus.int_req), 32'd0);
    step(1);
    chk("t3_req", 32'(bus.int_req), 32'd1);
    chk("t3_id", 32'(bus.int_id), 32'd0);
    chk("t3_vec", 32'(bus.int_vec), 32'h10);
    ack();
    rti();

    // Offer withdrawn when its mask bit is cleared before ack; pending retained.
    write_mask(4'b1111);
    bus.irq_in = 4'b0010;
    step(1);
    bus.irq_in = 4'b0000;
    step(2);
    chk("t4_req", 32'(bus.int_req), 32'd1);
    write_mask(4'b1101);
    chk("t4_withdrawn", 32'(bus.int_req), 32'd0);
    chk("t4_pending", 32'(bus.pending), 32'h2);
    step(1);
    chk("t4_still_off", 32'(bus.int_req), 32'd0);
    write_mask(4'b1111);
    step(1);
    chk("t4_reoffer", 32'(bus.int_req), 32'd1);
    chk("t4_reoffer_id", 32'(bus.int_id), 32'd1);
    ack();
    rti();

    // Three edges during service collapse into one pending event and one offer.
    bus.irq_in = 4'b0100;
    step(1);
    bus.irq_in = 4'b0000;
    step(2);
    ack();
    chk("t5_insvc", 32'(bus.in_service), 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus.irq_in = 4'b0001;
      step(1);
      bus.irq_in = 4'b0000;
      step(1);
    end
    step(1);
    chk("t5_pending", 32'(bus.pending), 32'h1);
    chk("t5_no_nest", 32'(bus.int_req), 32'd0);
    rti();
    chk("t5_req_rti", 32'(bus.int_req), 32'd0);
    step(1);
    chk("t5_req", 32'(bus.int_req), 32'd1);
    chk("t5_id", 32'(bus.int_id), 32'd0);
    ack();
    chk("t5_pending_ack", 32'(bus.pending), 32'h0);
    rti();
    step(1);
    chk("t5_single_offer", 32'(bus.int_req), 32'd0);

    // New edge arriving on the ack edge: set wins over clear.
    bus.irq_in = 4'b0001;
    step(1);
    bus.irq_in = 4'b0000;
    step(2);
    chk("t6_req", 32'(bus.int_req), 32'd1);
    bus.irq_in = 4'b0001;
    step(1);
    bus.irq_in = 4'b0000;
    chk("t6_req_hold", 32'(bus.int_req), 32'd1);
    ack();
    chk("t6_set_wins", 32'(bus.pending), 32'h1);
    chk("t6_insvc", 32'(bus.in_service), 32'd1);
    rti();
    step(1);
    chk("t6_reoffer", 32'(bus.int_req), 32'd1);

    // Reset mid-offer, with a source held high across reset release.
    bus.irq_in = 4'b0001;
    reset      = 1'b1;
    step(1);
    chk("t7_req", 32'(bus.int_req), 32'd0);
    chk("t7_vec", 32'(bus.int_vec), 32'd0);
    chk("t7_id", 32'(bus.int_id), 32'd0);
    chk("t7_pending", 32'(bus.pending), 32'h0);
    chk("t7_insvc", 32'(bus.in_service), 32'd0);
    chk("t7_wake", 32'(bus.ps_wake), 32'd0);
    reset = 1'b0;
    step(1);
    chk("t7_pending_first", 32'(bus.pending), 32'h0);
    step(1);
    chk("t7_held_edge", 32'(bus.pending), 32'h1);
    step(2);
    chk("t7_mask_zero", 32'(bus.int_req), 32'd0);
    bus.irq_in = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
